shift_reg_univ: RTL and testbench

//  Parametrised universal shift register: shift left/right, rotate, parallel load and clear.

---
 rtl/shift_reg_univ.sv | 101 ++++++++++
 tb/tb_shift_reg_univ.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register (shift, rotate, load, clear) paced by an internal prescaler strobe.
// Everything runs on CLK; TICK is an enable, never a derived clock.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int DIV_N = 134217728
) (
    input  logic                       CLK,
    input  logic                       R,
    input  logic                       CE,
    input  logic [2:0]                 MODE,
    input  logic                       SLI,
    input  logic                       SRI,
    input  logic [WIDTH-1:0]           D,
    output logic [WIDTH-1:0]           Q,
    output logic                       SLO,
    output logic                       SRO,
    output logic                       TICK,
    output logic [$clog2(WIDTH+1)-1:0] SHCNT,
    output logic                       FULL
);

    localparam int PW = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(DIV_N - 1);
    localparam logic [CW-1:0] SHCNT_MAX = CW'(WIDTH);

    localparam logic [2:0] MODE_SHL = 3'b001;
    localparam logic [2:0] MODE_SHR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;
    localparam logic [2:0] MODE_LD  = 3'b101;
    localparam logic [2:0] MODE_CLR = 3'b110;

    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    shcnt_q, shcnt_d;
    logic             tick;
    logic             is_shift;

    // With DIV_N=1 pcnt is pinned at 0 == PCNT_MAX, so the strobe is constant.
    assign tick = (pcnt_q == PCNT_MAX);

    always_comb begin
        pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
        q_d      = q_q;
        shcnt_d  = shcnt_q;
        is_shift = 1'b0;
        if (tick && CE) begin
            case (MODE)
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], SLI};
                    is_shift = 1'b1;
                end
                MODE_SHR: begin
                    q_d      = {SRI, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    is_shift = 1'b1;
                end
                MODE_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_LD: begin
                    q_d     = D;
                    shcnt_d = '0;
                end
                MODE_CLR: begin
                    q_d     = '0;
                    shcnt_d = '0;
                end
                default: ;
            endcase
        end
        if (is_shift && (shcnt_q != SHCNT_MAX)) begin
            shcnt_d = shcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            pcnt_q  <= '0;
            q_q     <= '0;
            shcnt_q <= '0;
        end else begin
            pcnt_q  <= pcnt_d;
            q_q     <= q_d;
            shcnt_q <= shcnt_d;
        end
    end

    assign Q     = q_q;
    assign SLO   = q_q[WIDTH-1];
    assign SRO   = q_q[0];
    assign TICK  = tick;
    assign SHCNT = shcnt_q;
    assign FULL  = (shcnt_q == SHCNT_MAX);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: a DIV_N=4 instance for prescaled operation
// and a DIV_N=1 instance for full-rate operation, both WIDTH=8.
module tb_shift_reg_univ;

    logic       clk_sys;
    logic       r, ce, sli, sri;
    logic [2:0] mode;
    logic [7:0] d, q;
    logic       slo, sro, tick, full;
    logic [3:0] shcnt;

    logic       r2, ce2, sli2, sri2;
    logic [2:0] mode2;
    logic [7:0] d2, q2;
    logic       slo2, sro2, tick2, full2;
    logic [3:0] shcnt2;

    int checks = 0;
    int errors = 0;

    shift_reg_univ #(.WIDTH(8), .DIV_N(4)) u_dut (
        .CLK(clk_sys), .R(r), .CE(ce), .MODE(mode), .SLI(sli), .SRI(sri), .D(d),
        .Q(q), .SLO(slo), .SRO(sro), .TICK(tick), .SHCNT(shcnt), .FULL(full)
    );

    shift_reg_univ #(.WIDTH(8), .DIV_N(1)) u_dut_fast (
        .CLK(clk_sys), .R(r2), .CE(ce2), .MODE(mode2), .SLI(sli2), .SRI(sri2), .D(d2),
        .Q(q2), .SLO(slo2), .SRO(sro2), .TICK(tick2), .SHCNT(shcnt2), .FULL(full2)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Advance to a cycle where TICK is high; the next posedge is the tick edge.
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("tick_reached", tick, 1);
    endtask

    task automatic do_op(input logic [2:0] m, input logic ce_v);
        mode = m;
        ce   = ce_v;
        wait_tick();
        step();
    endtask

    logic [7:0] exp_q;

    initial begin
        r = 1'b1; ce = 1'b0; mode = 3'b000; sli = 1'b0; sri = 1'b0; d = 8'h00;
        r2 = 1'b1; ce2 = 1'b0; mode2 = 3'b000; sli2 = 1'b0; sri2 = 1'b0; d2 = 8'h00;

        // 1: reset and tick phase
        repeat (3) step();
        r  = 1'b0;
        r2 = 1'b0;
        chk("rst_q", q, 8'h00);
        chk("rst_shcnt", shcnt, 0);
        chk("rst_full", full, 0);
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("tick_cycle%0d", c), tick, (c % 4 == 0) ? 1 : 0);
            step();
        end

        // 2: load and CE=0 hold
        d  = 8'hA5;
        do_op(3'b101, 1'b1);
        chk("load_q", q, 8'hA5);
        chk("load_shcnt", shcnt, 0);
        for (int i = 0; i < 3; i++) do_op(3'b110, 1'b0);
        chk("ce0_hold_q", q, 8'hA5);

        // 3: shift-left fill and saturation
        do_op(3'b110, 1'b1);
        chk("clear_q", q, 8'h00);
        sli = 1'b1;
        exp_q = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            do_op(3'b001, 1'b1);
            exp_q = {exp_q[6:0], 1'b1};
            chk($sformatf("shl_q%0d", i), q, exp_q);
            chk($sformatf("shl_cnt%0d", i), shcnt, i);
            chk($sformatf("shl_full%0d", i), full, (i == 8) ? 1 : 0);
        end
        do_op(3'b001, 1'b1);
        chk("shl9_cnt", shcnt, 8);
        chk("shl9_full", full, 1);
        sli = 1'b0;
        do_op(3'b001, 1'b1);
        chk("shl10_q", q, 8'hFE);
        chk("shl10_cnt", shcnt, 8);
        do_op(3'b000, 1'b1);
        chk("hold_q", q, 8'hFE);
        do_op(3'b111, 1'b1);
        chk("rsvd_q", q, 8'hFE);
        chk("rsvd_full", full, 1);

        // 4: rotates
        d = 8'hA5;
        do_op(3'b101, 1'b1);
        chk("rot_load_full", full, 0);
        chk("rot_sro", sro, 1);
        chk("rot_slo", slo, 1);
        do_op(3'b100, 1'b1);
        chk("ror1_q", q, 8'hD2);
        do_op(3'b100, 1'b1);
        chk("ror2_q", q, 8'h69);
        chk("ror2_cnt", shcnt, 2);
        do_op(3'b101, 1'b1);
        do_op(3'b011, 1'b1);
        chk("rol_q", q, 8'h4B);
        sri = 1'b0;
        do_op(3'b010, 1'b1);
        chk("shr_q", q, 8'h25);
        chk("shr_slo", slo, 0);

        // 5: reset mid-prescale
        d = 8'hA5;
        do_op(3'b101, 1'b1);
        do_op(3'b001, 1'b1);
        chk("pre_rst_cnt", shcnt, 1);
        step();
        r = 1'b1;
        step();
        r = 1'b0;
        chk("midrst_q", q, 8'h00);
        chk("midrst_cnt", shcnt, 0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("midrst_tick%0d", c), tick, (c == 4) ? 1 : 0);
            if (c < 4) step();
        end

        // 6: DIV_N=1 full-rate shift right
        chk("fast_tick", tick2, 1);
        chk("fast_rst_q", q2, 8'h00);
        ce2 = 1'b1; mode2 = 3'b010; sri2 = 1'b1;
        step();
        chk("fast_q1", q2, 8'h80);
        step();
        chk("fast_q2", q2, 8'hC0);
        step();
        chk("fast_q3", q2, 8'hE0);
        chk("fast_cnt3", shcnt2, 3);
        repeat (5) step();
        chk("fast_q8", q2, 8'hFF);
        chk("fast_full8", full2, 1);
        mode2 = 3'b110;
        step();
        chk("fast_clr_q", q2, 8'h00);
        chk("fast_clr_full", full2, 0);
        chk("fast_clr_cnt", shcnt2, 0);
        sli2 = 1'b1; d2 = 8'h3C; mode2 = 3'b101;
        step();
        chk("fast_load_q", q2, 8'h3C);
        mode2 = 3'b001;
        step();
        chk("fast_shl_q", q2, 8'h79);
        chk("fast_slo_sro", {slo2, sro2}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
